// File: rtl/ram_bank.sv
// ram_bank: register-file RAM with registered reads, hardware clear engine, reject strobe and flattened debug taps
module ram_bank #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AW-1:0]             adrs,
  input  logic [DW-1:0]             din,
  input  logic                      wr,
  input  logic                      rd,
  input  logic                      clr,
  output logic [DW-1:0]             dout,
  output logic                      dvalid,
  output logic                      busy,
  output logic                      rej,
  output logic [DW*(2**AW)-1:0]     taps
);
  localparam int DEPTH = 2**AW;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [AW-1:0] cnt;
  logic [DW-1:0] mem [DEPTH];
  logic idle;
  assign idle = state == IDLE;
  assign busy = state == CLEAR;
  always_comb begin
    state_nx = state;
    if (idle) state_nx = clr ? CLEAR : IDLE;
    else state_nx = cnt == AW'(DEPTH-1) ? IDLE : CLEAR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state <= IDLE;
      cnt <= '0;
      dout <= '0;
      dvalid <= 1'b0;
      rej <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= busy ? cnt + 1'b1 : '0;
      dvalid <= idle && rd;
      rej <= busy && (rd || wr);
      if (idle && rd) dout <= wr ? din : mem[adrs];
      if (idle && wr) mem[adrs] <= din;
      if (busy) mem[cnt] <= '0;
    end
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*DW +: DW] = mem[k];
  end
endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: table-driven and sequence checks of ram_bank at two parameter sets
module tb_ram_bank;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [1:0] adrs;
  logic [7:0] din, dout;
  logic wr, rd, clr, dvalid, busy, rej;
  logic [31:0] taps;
  logic [3:0] adrs2;
  logic [15:0] din2, dout2;
  logic wr2, rd2, clr2, dvalid2, busy2, rej2;
  logic [255:0] taps2;
  int n_chk = 0, n_fail = 0;
  ram_bank #(.DW(8), .AW(2)) dut (
    .clk(clk), .rst(rst), .adrs(adrs), .din(din), .wr(wr), .rd(rd), .clr(clr),
    .dout(dout), .dvalid(dvalid), .busy(busy), .rej(rej), .taps(taps)
  );
  ram_bank #(.DW(16), .AW(4)) dut2 (
    .clk(clk), .rst(rst), .adrs(adrs2), .din(din2), .wr(wr2), .rd(rd2), .clr(clr2),
    .dout(dout2), .dvalid(dvalid2), .busy(busy2), .rej(rej2), .taps(taps2)
  );
  typedef struct {
    logic r, w, rd, c;
    logic [1:0] a;
    logic [7:0] d, edout;
    logic edv, ebusy, erej;
    logic [31:0] etaps;
  } vec_t;
  vec_t q[$];
  function automatic vec_t mk(logic r, logic w, logic rd_i, logic c, logic [1:0] a, logic [7:0] d,
                              logic [7:0] edout, logic edv, logic ebusy, logic erej, logic [31:0] etaps);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd_i; v.c = c; v.a = a; v.d = d;
    v.edout = edout; v.edv = edv; v.ebusy = ebusy; v.erej = erej; v.etaps = etaps;
    return v;
  endfunction
  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    int n;
    {adrs, din, wr, rd, clr} = '0;
    {adrs2, din2, wr2, rd2, clr2} = '0;
    //          r  w  rd c  a  din    dout  dv bsy rej taps
    q.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 32'h00000000));
    q.push_back(mk(0, 1, 0, 0, 0, 8'h11, 8'h00, 0, 0, 0, 32'h00000011));
    q.push_back(mk(0, 1, 0, 0, 1, 8'h22, 8'h00, 0, 0, 0, 32'h00002211));
    q.push_back(mk(0, 1, 0, 0, 2, 8'h33, 8'h00, 0, 0, 0, 32'h00332211));
    q.push_back(mk(0, 1, 0, 0, 3, 8'h44, 8'h00, 0, 0, 0, 32'h44332211));
    q.push_back(mk(0, 0, 1, 0, 2, 8'h00, 8'h33, 1, 0, 0, 32'h44332211));
    q.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h33, 0, 0, 0, 32'h44332211));
    q.push_back(mk(0, 1, 1, 0, 1, 8'hA5, 8'hA5, 1, 0, 0, 32'h4433A511));
    q.push_back(mk(0, 1, 0, 0, 1, 8'h22, 8'hA5, 0, 0, 0, 32'h44332211));
    q.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hA5, 0, 1, 0, 32'h44332211));
    q.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hA5, 0, 1, 0, 32'h44332200));
    q.push_back(mk(0, 1, 0, 0, 3, 8'hFF, 8'hA5, 0, 1, 1, 32'h44330000));
    q.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hA5, 0, 1, 0, 32'h44000000));
    q.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hA5, 0, 0, 0, 32'h00000000));
    q.push_back(mk(0, 1, 0, 0, 0, 8'h11, 8'hA5, 0, 0, 0, 32'h00000011));
    q.push_back(mk(0, 1, 0, 0, 1, 8'h22, 8'hA5, 0, 0, 0, 32'h00002211));
    q.push_back(mk(0, 1, 0, 0, 2, 8'h33, 8'hA5, 0, 0, 0, 32'h00332211));
    q.push_back(mk(0, 1, 0, 0, 3, 8'h44, 8'hA5, 0, 0, 0, 32'h44332211));
    q.push_back(mk(0, 0, 1, 1, 3, 8'h00, 8'h44, 1, 1, 0, 32'h44332211));
    q.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h44, 0, 1, 1, 32'h44332200));
    q.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 32'h00000000));
    q.push_back(mk(0, 1, 0, 0, 0, 8'h5A, 8'h00, 0, 0, 0, 32'h0000005A));
    q.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h5A, 1, 0, 0, 32'h0000005A));
    foreach (q[i]) begin
      @(negedge clk);
      rst = q[i].r; wr = q[i].w; rd = q[i].rd; clr = q[i].c; adrs = q[i].a; din = q[i].d;
      @(posedge clk); #1;
      check($sformatf("v%0d dout", i), 256'(dout), 256'(q[i].edout));
      check($sformatf("v%0d dvalid", i), 256'(dvalid), 256'(q[i].edv));
      check($sformatf("v%0d busy", i), 256'(busy), 256'(q[i].ebusy));
      check($sformatf("v%0d rej", i), 256'(rej), 256'(q[i].erej));
      check($sformatf("v%0d taps", i), 256'(taps), 256'(q[i].etaps));
    end
    @(negedge clk);
    {rst, wr, rd, clr} = '0;
    wr2 = 1; adrs2 = 15; din2 = 16'hBEEF;
    @(posedge clk); #1;
    check("w16 taps", taps2, {16'hBEEF, 240'h0});
    @(negedge clk);
    wr2 = 0; rd2 = 1;
    @(posedge clk); #1;
    check("w16 dout", 256'(dout2), 256'(16'hBEEF));
    check("w16 dvalid", 256'(dvalid2), 256'(1'b1));
    @(negedge clk);
    rd2 = 0; clr2 = 1;
    @(posedge clk); #1;
    clr2 = 0;
    n = 0;
    for (int i = 0; i < 40 && busy2; i++) begin
      n++;
      @(posedge clk); #1;
    end
    check("w16 busy cycles", 256'(n), 256'(16));
    check("w16 taps clear", taps2, 256'h0);
    check("w16 dvalid idle", 256'(dvalid2), 256'(1'b0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
